// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input and memory-write output bundle for instr_encoder
interface instr_encoder_if #(
  parameter int ADDR_W = 16
);
  // Decoded field bundle from the loader
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [3:0]        in_fn;
  logic [3:0]        in_rd;
  logic [3:0]        in_rs1;
  logic [3:0]        in_rs2;
  logic [15:0]       in_imm;

  // Instruction-memory write request
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_word;

  // Loader / memory side
  modport master (
    output in_valid, in_opcode, in_fn, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_addr, out_word
  );

  // Encoder side
  modport slave (
    input  in_valid, in_opcode, in_fn, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_addr, out_word
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - legality-checks decoded fields, packs them into words, writes them to memory
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  instr_encoder_if.slave    bus,
  output logic              err_illegal,
  output logic [7:0]        drop_count,
  output logic [ADDR_W-1:0] words_out
);
  localparam int WORD_SIZE = 32;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Opcodes
  localparam logic [3:0] OP_ALUR   = 4'hC;
  localparam logic [3:0] OP_ALUI   = 4'h4;
  localparam logic [3:0] OP_CMPR   = 4'hD;
  localparam logic [3:0] OP_CMPI   = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h7;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h2;
  localparam logic [3:0] OP_JAL    = 4'h6;

  // ALU function codes
  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_AND  = 4'h4;
  localparam logic [3:0] FN_OR   = 4'h5;
  localparam logic [3:0] FN_XOR  = 4'h6;
  localparam logic [3:0] FN_NAND = 4'hC;
  localparam logic [3:0] FN_NOR  = 4'hD;
  localparam logic [3:0] FN_XNOR = 4'hE;
  localparam logic [3:0] FN_MVHI = 4'hF;

  // Compare function codes
  localparam logic [3:0] FN_F   = 4'h0;
  localparam logic [3:0] FN_EQ  = 4'h1;
  localparam logic [3:0] FN_LT  = 4'h2;
  localparam logic [3:0] FN_LTE = 4'h3;
  localparam logic [3:0] FN_T   = 4'h8;
  localparam logic [3:0] FN_NE  = 4'h9;
  localparam logic [3:0] FN_GTE = 4'hA;
  localparam logic [3:0] FN_GT  = 4'hB;

  // Branch function codes
  localparam logic [3:0] FN_BF    = 4'h0;
  localparam logic [3:0] FN_BEQ   = 4'h1;
  localparam logic [3:0] FN_BLT   = 4'h2;
  localparam logic [3:0] FN_BLTE  = 4'h3;
  localparam logic [3:0] FN_BEQZ  = 4'h5;
  localparam logic [3:0] FN_BLTZ  = 4'h6;
  localparam logic [3:0] FN_BLTEZ = 4'h7;
  localparam logic [3:0] FN_BT    = 4'h8;
  localparam logic [3:0] FN_BNE   = 4'h9;
  localparam logic [3:0] FN_BGTE  = 4'hA;
  localparam logic [3:0] FN_BGT   = 4'hB;
  localparam logic [3:0] FN_BNEZ  = 4'hD;
  localparam logic [3:0] FN_BGTEZ = 4'hE;
  localparam logic [3:0] FN_BGTZ  = 4'hF;

  logic [WORD_SIZE-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic [WORD_SIZE-1:0] last_word;
  logic [WORD_SIZE-1:0] enc_word;
  logic [ADDR_W-1:0]    addr_q;
  logic                 legal;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 push;
  logic                 pop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  // A pop offered during clear is discarded along with the rest of the FIFO
  assign pop    = bus.out_valid && bus.out_ready && !clear;

  assign bus.in_ready  = !full && !clear && !reset;
  assign bus.out_valid = !empty;
  // Once drained, keep presenting the last word written rather than a stale slot
  assign bus.out_word  = empty ? last_word : fifo_mem[rd_ptr];
  assign bus.out_addr  = addr_q;

  // Legality: opcode must be known and fn must belong to that opcode's class
  always_comb begin
    legal = 1'b0;
    case (bus.in_opcode)
      OP_ALUR, OP_ALUI:
        legal = bus.in_fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
                                  FN_NAND, FN_NOR, FN_XNOR, FN_MVHI};
      OP_CMPR, OP_CMPI:
        legal = bus.in_fn inside {FN_F, FN_EQ, FN_LT, FN_LTE,
                                  FN_T, FN_NE, FN_GTE, FN_GT};
      OP_BRANCH:
        legal = bus.in_fn inside {FN_BF, FN_BEQ, FN_BLT, FN_BLTE, FN_BEQZ,
                                  FN_BLTZ, FN_BLTEZ, FN_BT, FN_BNE, FN_BGTE,
                                  FN_BGT, FN_BNEZ, FN_BGTEZ, FN_BGTZ};
      OP_LOAD, OP_STORE, OP_JAL:
        legal = 1'b1;
      default:
        legal = 1'b0;
    endcase
  end

  // Field packing: register forms, immediate forms, and store/branch which carry rs2 low
  always_comb begin
    enc_word = '0;
    case (bus.in_opcode)
      OP_ALUR, OP_CMPR:
        enc_word = {bus.in_fn, bus.in_opcode, 12'h000, bus.in_rs2, bus.in_rs1, bus.in_rd};
      OP_STORE, OP_BRANCH:
        enc_word = {bus.in_fn, bus.in_opcode, bus.in_imm, bus.in_rs1, bus.in_rs2};
      default:
        enc_word = {bus.in_fn, bus.in_opcode, bus.in_imm, bus.in_rs1, bus.in_rd};
    endcase
  end

  // FIFO storage; push is already gated off during reset and clear
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= enc_word;
    end
  end

  // Pointers, occupancy, write address and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_word   <= '0;
      addr_q      <= BASE_ADDR;
      words_out   <= '0;
      err_illegal <= 1'b0;
      drop_count  <= '0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      addr_q      <= BASE_ADDR;
      words_out   <= '0;
      err_illegal <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_word <= fifo_mem[rd_ptr];
        addr_q    <= addr_q + ADDR_W'(4);
        words_out <= words_out + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && !legal) begin
        err_illegal <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] BASE   = 16'h0100;

  localparam logic [3:0] OP_ALUR   = 4'hC;
  localparam logic [3:0] OP_ALUI   = 4'h4;
  localparam logic [3:0] OP_CMPR   = 4'hD;
  localparam logic [3:0] OP_CMPI   = 4'h5;
  localparam logic [3:0] OP_LOAD   = 4'h7;
  localparam logic [3:0] OP_STORE  = 4'h3;
  localparam logic [3:0] OP_BRANCH = 4'h2;
  localparam logic [3:0] OP_JAL    = 4'h6;
  localparam logic [3:0] FN_ADD    = 4'h0;
  localparam logic [3:0] FN_MVHI   = 4'hF;
  localparam logic [3:0] FN_EQ     = 4'h1;
  localparam logic [3:0] FN_GT     = 4'hB;
  localparam logic [3:0] FN_BNE    = 4'h9;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  fn;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  localparam int NVEC = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        err_illegal;
  logic [7:0]  drop_count;
  logic [15:0] words_out;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .bus         (bus),
    .err_illegal (err_illegal),
    .drop_count  (drop_count),
    .words_out   (words_out)
  );

  always #5 clk = ~clk;

  vec_t        vecs [NVEC];
  int          legal_idx [$];
  int          illegal_idx [$];
  logic [31:0] exp_q [$];
  logic [15:0] exp_addr = BASE;
  int          exp_drop;
  bit          exp_err;
  int          exp_words;
  int          rdy_mode;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          hold_chk = 1'b0;
  logic [31:0] hold_word;
  logic [15:0] hold_addr;
  logic [31:0] last_legal;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Scoreboard: compare every accepted memory write, and check held outputs while stalled
  always @(negedge clk) begin
    if (reset || clear) begin
      exp_q.delete();
      exp_addr = BASE;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk && bus.out_valid) begin
        check("hold_word", bus.out_word, hold_word);
        check("hold_addr", {16'h0, bus.out_addr}, {16'h0, hold_addr});
      end
      hold_chk = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got %h expected no write", bus.out_word);
        end else begin
          check("write_word", bus.out_word, exp_q.pop_front());
          check("write_addr", {16'h0, bus.out_addr}, {16'h0, exp_addr});
        end
        exp_addr = exp_addr + 16'd4;
      end else if (bus.out_valid) begin
        hold_chk  = 1'b1;
        hold_word = bus.out_word;
        hold_addr = bus.out_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
    else bus.out_ready = (rdy_mode == 1);
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_opcode = v.op;
    bus.in_fn     = v.fn;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_imm    = v.imm;
  endtask

  task automatic send(input vec_t v);
    int waited = 0;
    drive(v);
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (v.legal) begin
          exp_q.push_back(v.word);
          exp_words++;
          last_legal = v.word;
        end else begin
          exp_err = 1'b1;
          if (exp_drop < 255) exp_drop++;
        end
        tick();
        break;
      end
      waited++;
      if (waited > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready got 0 expected 1");
        tick();
        break;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && waited < 300) begin
      tick();
      waited++;
    end
    n_checks++;
    if (waited >= 300) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_drop  = 0;
    exp_err   = 1'b0;
    exp_words = 0;
    check("clr_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("clr_out_addr", {16'h0, bus.out_addr}, {16'h0, BASE});
    check("clr_err", {31'h0, err_illegal}, 32'h0);
    check("clr_drop", {24'h0, drop_count}, 32'h0);
    check("clr_words_out", {16'h0, words_out}, 32'h0);
  endtask

  initial begin
    vec_t v5;
    // op, fn, rd, rs1, rs2, imm, legal, word
    vecs[0]  = '{OP_ALUR,   FN_ADD,  4'h1, 4'h2, 4'h3, 16'h0000, 1'b1, 32'h0C000321};
    vecs[1]  = '{OP_ALUI,   FN_ADD,  4'h6, 4'h5, 4'h9, 16'hFFFE, 1'b1, 32'h04FFFE56};
    vecs[2]  = '{OP_BRANCH, FN_BNE,  4'h3, 4'h7, 4'h8, 16'h0010, 1'b1, 32'h92001078};
    vecs[3]  = '{OP_CMPR,   FN_MVHI, 4'h1, 4'h2, 4'h3, 16'h0000, 1'b0, 32'h0};
    vecs[4]  = '{OP_CMPI,   FN_GT,   4'hB, 4'hA, 4'h0, 16'h1234, 1'b1, 32'hB51234AB};
    vecs[5]  = '{OP_LOAD,   4'h7,    4'h2, 4'h1, 4'h5, 16'h8000, 1'b1, 32'h77800012};
    vecs[6]  = '{OP_STORE,  4'h0,    4'hF, 4'h3, 4'h4, 16'h0004, 1'b1, 32'h03000434};
    vecs[7]  = '{OP_JAL,    4'h0,    4'hF, 4'hE, 4'h1, 16'h0000, 1'b1, 32'h060000EF};
    vecs[8]  = '{4'h0,      4'h0,    4'h1, 4'h1, 4'h1, 16'h0001, 1'b0, 32'h0};
    vecs[9]  = '{OP_ALUR,   4'h2,    4'h1, 4'h1, 4'h1, 16'h0000, 1'b0, 32'h0};
    vecs[10] = '{OP_BRANCH, 4'hC,    4'h1, 4'h1, 4'h1, 16'h0000, 1'b0, 32'h0};
    vecs[11] = '{OP_ALUR,   FN_MVHI, 4'h1, 4'h0, 4'h0, 16'hABCD, 1'b1, 32'hFC000001};
    vecs[12] = '{OP_CMPR,   FN_EQ,   4'h4, 4'h5, 4'h6, 16'h0000, 1'b1, 32'h1D000654};
    vecs[13] = '{4'hF,      4'h0,    4'h1, 4'h1, 4'h1, 16'h0000, 1'b0, 32'h0};
    vecs[14] = '{OP_ALUI,   4'h8,    4'h1, 4'h1, 4'h1, 16'h0000, 1'b0, 32'h0};
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].legal) legal_idx.push_back(i);
      else illegal_idx.push_back(i);
    end

    reset = 1'b1;
    clear = 1'b0;
    rdy_mode = 0;
    bus.in_valid = 1'b0;
    bus.in_opcode = '0; bus.in_fn = '0; bus.in_rd = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.out_ready = 1'b0;
    exp_drop = 0; exp_err = 1'b0; exp_words = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("rst_out_word", bus.out_word, 32'h0);
    check("rst_out_addr", {16'h0, bus.out_addr}, {16'h0, BASE});
    check("rst_err", {31'h0, err_illegal}, 32'h0);
    check("rst_drop", {24'h0, drop_count}, 32'h0);
    check("rst_words_out", {16'h0, words_out}, 32'h0);
    check("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    tick();
    reset = 1'b0;

    // One-cycle latency, output held while stalled
    tick();
    send(vecs[0]);
    check("lat_out_valid", {31'h0, bus.out_valid}, 32'h1);
    check("lat_out_word", bus.out_word, 32'h0C000321);
    check("lat_out_addr", {16'h0, bus.out_addr}, {16'h0, BASE});
    tick();
    tick();
    rdy_mode = 1;
    drain();
    check("lat_words_out", {16'h0, words_out}, 32'd1);

    // Illegal bundle dropped, next legal still lands at BASE
    clear_pulse();
    send(vecs[3]);
    check("ill_err", {31'h0, err_illegal}, 32'h1);
    check("ill_drop", {24'h0, drop_count}, 32'd1);
    check("ill_no_write", {31'h0, bus.out_valid}, 32'h0);
    send(vecs[1]);
    drain();

    // Full vector table back to back
    clear_pulse();
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i]);
      check("tbl_drop", {24'h0, drop_count}, exp_drop);
      check("tbl_err", {31'h0, err_illegal}, {31'h0, exp_err});
    end
    drain();
    check("tbl_words_out", {16'h0, words_out}, exp_words);
    check("tbl_empty_holds", bus.out_word, last_legal);

    // Fill to DEPTH with memory stalled, then release
    clear_pulse();
    rdy_mode = 0;
    tick();
    for (int i = 0; i < DEPTH; i++) send(vecs[legal_idx[i]]);
    v5 = vecs[legal_idx[DEPTH]];
    drive(v5);
    @(negedge clk);
    check("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("full_head", bus.out_word, vecs[legal_idx[0]].word);
    tick();
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    drain();
    check("full_words_out", {16'h0, words_out}, DEPTH);
    check("full_out_addr", {16'h0, bus.out_addr}, {16'h0, BASE + 16'(4 * DEPTH)});

    // Drop counter saturation
    clear_pulse();
    for (int i = 0; i < 260; i++) send(vecs[illegal_idx[i % illegal_idx.size()]]);
    check("sat_drop", {24'h0, drop_count}, 32'd255);
    check("sat_err", {31'h0, err_illegal}, 32'h1);

    // Streaming with random memory backpressure and a clear mid-stream
    clear_pulse();
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) send(vecs[$urandom_range(0, NVEC - 1)]);
    clear_pulse();
    for (int i = 0; i < 30; i++) send(vecs[$urandom_range(0, NVEC - 1)]);
    drain();
    check("stream_words_out", {16'h0, words_out}, exp_words);

    // Asynchronous reset mid-stream
    rdy_mode = 0;
    tick();
    send(vecs[0]);
    send(vecs[1]);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("arst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("arst_out_addr", {16'h0, bus.out_addr}, {16'h0, BASE});
    check("arst_out_word", bus.out_word, 32'h0);
    tick();
    reset = 1'b0;
    exp_drop = 0; exp_err = 1'b0; exp_words = 0;
    rdy_mode = 1;
    send(vecs[2]);
    drain();
    check("arst_words_out", {16'h0, words_out}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
